// File: rtl/dram_bridge.sv
// rtl/dram_bridge.sv - single-outstanding command bridge onto an AXI-style DRAM read/write port
module dram_bridge #(
    parameter logic [16:0] BASE_ADDR  = 17'h10000,
    parameter int          DATA_BYTES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        C_in_valid,
    input  logic [7:0]  C_addr,
    input  logic [63:0] C_data_w,
    input  logic        C_r_wb,
    output logic        C_out_valid,
    output logic [63:0] C_data_r,
    output logic        AR_VALID,
    input  logic        AR_READY,
    output logic [16:0] AR_ADDR,
    input  logic        R_VALID,
    output logic        R_READY,
    input  logic [63:0] R_DATA,
    input  logic [1:0]  R_RESP,
    output logic        AW_VALID,
    input  logic        AW_READY,
    output logic [16:0] AW_ADDR,
    output logic        W_VALID,
    input  logic        W_READY,
    output logic [63:0] W_DATA,
    input  logic        B_VALID,
    output logic        B_READY,
    input  logic [1:0]  B_RESP
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    state_t      state;
    logic [63:0] data_q;
    logic [16:0] req_addr;

    // Responses are never inspected: an error response completes the request like OKAY.
    logic unused_resp;
    assign unused_resp = ^{R_RESP, B_RESP};

    // Byte address of the requested entry, wrapping within the 17-bit DRAM space.
    assign req_addr = BASE_ADDR + 17'(C_addr) * 17'(DATA_BYTES);

    // Request sequencer; every output is a register updated only here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            data_q      <= '0;
            C_out_valid <= 1'b0;
            C_data_r    <= '0;
            AR_VALID    <= 1'b0;
            AR_ADDR     <= '0;
            R_READY     <= 1'b0;
            AW_VALID    <= 1'b0;
            AW_ADDR     <= '0;
            W_VALID     <= 1'b0;
            W_DATA      <= '0;
            B_READY     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The completion pulse lasts exactly one cycle, and this is that cycle.
                    C_out_valid <= 1'b0;
                    C_data_r    <= '0;
                    if (C_in_valid) begin
                        data_q <= C_data_w;
                        if (C_r_wb) begin
                            AR_VALID <= 1'b1;
                            AR_ADDR  <= req_addr;
                            state    <= RD_ADDR;
                        end else begin
                            AW_VALID <= 1'b1;
                            AW_ADDR  <= req_addr;
                            state    <= WR_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (AR_READY) begin
                        AR_VALID <= 1'b0;
                        R_READY  <= 1'b1;
                        state    <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (R_VALID) begin
                        R_READY     <= 1'b0;
                        C_data_r    <= R_DATA;
                        C_out_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                WR_ADDR: begin
                    // Data phase starts only after the address is accepted.
                    if (AW_READY) begin
                        AW_VALID <= 1'b0;
                        W_VALID  <= 1'b1;
                        W_DATA   <= data_q;
                        state    <= WR_DATA;
                    end
                end
                WR_DATA: begin
                    if (W_READY) begin
                        W_VALID <= 1'b0;
                        B_READY <= 1'b1;
                        state   <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (B_VALID) begin
                        B_READY     <= 1'b0;
                        C_data_r    <= '0;
                        C_out_valid <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dram_bridge.md
DRAM_BRIDGE -- requirements
Module: dram_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 17'h10000, meaning the DRAM byte address of Data_No 0.
REQ-002 SHALL have parameter DATA_BYTES, default 8, meaning the byte stride per Data_No entry.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports (name  direction  width  meaning), one per line:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- C_in_valid  in  1  program request strobe, one cycle.
- C_addr  in  8  Data_No to access.
- C_data_w  in  64  write data; Data_Dir in bits [56:0], bits [63:57] zero.
- C_r_wb  in  1  1 = read, 0 = write.
- C_out_valid  out  1  request done, one-cycle pulse.
- C_data_r  out  64  read data, valid with C_out_valid.
- AR_VALID, AR_READY  out, in  1  read-address handshake.
- AR_ADDR  out  17  read address.
- R_VALID, R_READY  in, out  1  read-data handshake.
- R_DATA  in  64  read data.
- R_RESP  in  2  read response.
- AW_VALID, AW_READY  out, in  1  write-address handshake.
- AW_ADDR  out  17  write address.
- W_VALID, W_READY  out, in  1  write-data handshake.
- W_DATA  out  64  write data.
- B_VALID, B_READY  in, out  1  write-response handshake.
- B_RESP  in  2  write response.

Function
REQ-005 SHALL implement FSM states IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP.
REQ-006 SHALL drive every output from a register; no combinational input-to-output path.
REQ-007 In IDLE, when C_in_valid=1, SHALL latch C_addr, C_data_w and C_r_wb, then go to RD_ADDR (read) or WR_ADDR (write) on the next edge.
REQ-008 SHALL ignore C_in_valid in every state except IDLE, with no queuing.
REQ-009 SHALL compute AR_ADDR and AW_ADDR as BASE_ADDR + latched C_addr*DATA_BYTES, truncated to 17 bits; Data_No 8'hFF gives 17'h107F8.
REQ-010 RD_ADDR: SHALL hold AR_VALID=1 with stable AR_ADDR until AR_READY=1 is sampled; on that edge SHALL drop AR_VALID and go to RD_DATA.
REQ-011 RD_DATA: SHALL hold R_READY=1; on an edge with R_VALID=1 SHALL capture R_DATA into C_data_r, pulse C_out_valid for one cycle, drop R_READY and return to IDLE.
REQ-012 WR_ADDR: SHALL hold AW_VALID=1 with stable AW_ADDR until AW_READY=1 is sampled; then SHALL go to WR_DATA.
REQ-013 WR_DATA: SHALL hold W_VALID=1 with W_DATA equal to the latched C_data_w until W_READY=1 is sampled; then SHALL go to WR_RESP.
REQ-014 WR_RESP: SHALL hold B_READY=1; on an edge with B_VALID=1 SHALL pulse C_out_valid with C_data_r=0 and return to IDLE.
REQ-015 SHALL issue AW and W sequentially, never at the same time, and only one transaction at a time.
REQ-016 SHALL drive C_data_r=0 whenever C_out_valid=0.
REQ-017 SHALL ignore R_VALID and B_VALID in states other than RD_DATA and WR_RESP.
REQ-018 SHALL treat a nonzero R_RESP or B_RESP exactly like OKAY, with no retry.
REQ-019 Latency with a zero-wait slave SHALL be: read, C_in_valid at cycle 0 -> AR_VALID at cycle 1 -> R_READY at cycle 2 -> C_out_valid at cycle 3; write -> C_out_valid at cycle 4.
REQ-020 SHALL accept a new C_in_valid in the cycle that C_out_valid is high, since the FSM is then in IDLE.

Reset
REQ-021 When rst=1 at a clock edge, SHALL enter IDLE and clear all outputs and latched registers to 0 on that edge.
REQ-022 Reset in any state SHALL abort the transaction: all VALID/READY outputs are 0 after the edge and no C_out_valid pulse is issued.

Verification
REQ-023 Read, C_addr=8'h03, zero-wait slave, R_DATA=64'h0123_4567_89AB_CDEF -> AR_ADDR=17'h10018, then C_out_valid at cycle 3 with C_data_r=64'h0123_4567_89AB_CDEF.
REQ-024 Write, C_addr=8'hFF, C_data_w=64'h00AA, AW_READY delayed 5 cycles, W_READY delayed 2 cycles -> AW_ADDR=17'h107F8 stable while waiting, W_DATA=64'h00AA, one C_out_valid pulse after B_VALID, with C_data_r=0.
REQ-025 Second C_in_valid issued while in RD_DATA -> ignored; only one AR handshake occurs and only one C_out_valid pulse.
REQ-026 rst=1 in WR_DATA with W_VALID=1 -> all outputs 0 next cycle; no C_out_valid pulse; a following read completes normally.
REQ-027 R_RESP=2'b10 on the read -> data still returned with the normal C_out_valid timing.
REQ-028 Back-to-back requests, new C_in_valid in the C_out_valid cycle -> accepted, AR_VALID on the next cycle.
